// File: rtl/mem_request_sequencer.sv
// mem_request_sequencer
// Purpose:
//   Sits upstream of memory_interface. It accepts one load or store per
//   valid/ready handshake from the execute stage and holds the memory
//   controls stable for the whole access. It then waits for mi_output_valid
//   (load) or mi_write_ready (store) and returns the result to writeback
//   through a valid/ready response. Only one transaction is outstanding at a
//   time, so responses are never reordered.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   req_*               request channel from execute (valid/ready)
//   mi_*                control/data to and status from memory_interface
//   rsp_*               response channel to writeback (valid/ready)
// Parameters:
//   ADDR_WIDTH          line address width (16-bit memory lines)
//   RD_WIDTH            destination register index width
//   TIMEOUT             max cycles spent in WAIT before aborting (>= 2)

module mem_request_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int RD_WIDTH   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_word_type,
  input  logic                  req_signed,
  input  logic [RD_WIDTH-1:0]   req_rd,
  output logic [ADDR_WIDTH-1:0] mi_address,
  output logic [31:0]           mi_data_in,
  output logic                  mi_load,
  output logic                  mi_store,
  output logic                  mi_is_signed,
  output logic [1:0]            mi_word_type,
  input  logic [31:0]           mi_data_out,
  input  logic                  mi_output_valid,
  input  logic                  mi_write_ready,
  input  logic                  mi_busy,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_is_load,
  output logic [RD_WIDTH-1:0]   rsp_rd,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic                  r_isStore;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_wordType;
  logic                  r_signed;
  logic [RD_WIDTH-1:0]   r_rd;
  logic [CNT_W-1:0]      r_waitCount;
  logic [31:0]           r_rspData;
  logic                  r_rspErr;

  logic w_reject;
  logic w_done;
  logic w_timeout;
  logic w_miActive;

  // A word access reads two consecutive lines, so a word at the last line
  // would wrap its second half to address 0; that and the reserved word type
  // are refused without ever touching memory.
  assign w_reject  = (req_word_type == 2'b11) ||
                     ((req_word_type == 2'b10) && (req_addr == {ADDR_WIDTH{1'b1}}));
  assign w_done    = r_isStore ? mi_write_ready : mi_output_valid;
  assign w_timeout = (r_waitCount == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Completion is checked before the timeout so that a
  // completion landing on the final WAIT cycle is still reported as good.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (req_valid) w_nextState = w_reject ? RESP : ISSUE;
      ISSUE: if (!mi_busy) w_nextState = WAIT;
      WAIT:  if (w_done || w_timeout) w_nextState = RESP;
      RESP:  if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Request register, WAIT-cycle counter and response capture. The request
  // is latched on every accept, including rejected ones, so that the error
  // response still reports the destination register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_isStore   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wordType  <= 2'b00;
      r_signed    <= 1'b0;
      r_rd        <= '0;
      r_waitCount <= '0;
      r_rspData   <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_isStore   <= req_is_store;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_wordType  <= req_word_type;
            r_signed    <= req_signed;
            r_rd        <= req_rd;
            r_waitCount <= '0;
            r_rspData   <= '0;
            r_rspErr    <= w_reject;
          end
        end
        WAIT: begin
          if (w_done) begin
            if (!r_isStore) r_rspData <= mi_data_out;
            r_rspErr <= 1'b0;
          end else if (w_timeout) begin
            r_rspData <= '0;
            r_rspErr  <= 1'b1;
          end else begin
            r_waitCount <= r_waitCount + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory-side outputs come straight from the request register while an
  // access is in flight and read as zero otherwise. Because of this, an
  // asynchronous reset clears them the moment the state drops back to IDLE.
  assign w_miActive   = (r_state == ISSUE) || (r_state == WAIT);
  assign mi_address   = w_miActive ? r_addr     : '0;
  assign mi_data_in   = w_miActive ? r_wdata    : '0;
  assign mi_word_type = w_miActive ? r_wordType : 2'b00;
  assign mi_is_signed = w_miActive ? r_signed   : 1'b0;

  // ISSUE always leaves for WAIT in the cycle the strobe fires, so the
  // strobe is exactly one cycle wide.
  assign mi_load  = (r_state == ISSUE) && !mi_busy && !r_isStore;
  assign mi_store = (r_state == ISSUE) && !mi_busy &&  r_isStore;

  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = (r_state == RESP);
  assign rsp_is_load = rsp_valid && !r_isStore && !r_rspErr;
  assign rsp_rd      = rsp_valid ? r_rd      : '0;
  assign rsp_data    = rsp_valid ? r_rspData : '0;
  assign rsp_err     = rsp_valid && r_rspErr;

endmodule

// File: tb/tb_mem_request_sequencer.sv
// tb_mem_request_sequencer
// Purpose:
//   Directed bench for mem_request_sequencer. A small behavioural model of
//   memory_interface (16-bit lines, configurable latency, optional silence)
//   answers the strobes. Expected responses are queued when each request is
//   driven and are compared when the response handshake appears.

module tb_mem_request_sequencer;

  localparam int ADDR_WIDTH = 12;
  localparam int RD_WIDTH   = 4;
  localparam int TIMEOUT    = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [1:0]            req_word_type;
  logic                  req_signed;
  logic [RD_WIDTH-1:0]   req_rd;
  logic [ADDR_WIDTH-1:0] mi_address;
  logic [31:0]           mi_data_in;
  logic                  mi_load;
  logic                  mi_store;
  logic                  mi_is_signed;
  logic [1:0]            mi_word_type;
  logic [31:0]           mi_data_out;
  logic                  mi_output_valid;
  logic                  mi_write_ready;
  logic                  mi_busy;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_is_load;
  logic [RD_WIDTH-1:0]   rsp_rd;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  typedef struct {
    logic                isLoad;
    logic [RD_WIDTH-1:0] rd;
    logic [31:0]         data;
    logic                err;
  } rsp_t;

  rsp_t expQ[$];

  int testCount = 0;
  int failCount = 0;

  logic [15:0] mem [0:(1<<ADDR_WIDTH)-1];
  int  memLatency = 0;
  bit  memNoResp  = 0;
  bit  pendActive = 0;
  bit  pendLoad   = 0;
  int  pendCnt    = 0;
  logic [ADDR_WIDTH-1:0] pendAddr;
  logic [31:0]           pendData;
  logic [1:0]            pendType;
  logic                  pendSigned;
  int  loadPulses  = 0;
  int  storePulses = 0;
  logic [1:0]            lastWordType = 2'b00;
  logic [ADDR_WIDTH-1:0] lastAddr = '0;

  mem_request_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RD_WIDTH  (RD_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_word_type  (req_word_type),
    .req_signed     (req_signed),
    .req_rd         (req_rd),
    .mi_address     (mi_address),
    .mi_data_in     (mi_data_in),
    .mi_load        (mi_load),
    .mi_store       (mi_store),
    .mi_is_signed   (mi_is_signed),
    .mi_word_type   (mi_word_type),
    .mi_data_out    (mi_data_out),
    .mi_output_valid(mi_output_valid),
    .mi_write_ready (mi_write_ready),
    .mi_busy        (mi_busy),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_is_load    (rsp_is_load),
    .rsp_rd         (rsp_rd),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural memory_interface: strobes are seen on the falling edge, the
  // access completes memLatency falling edges later, and the completion flag
  // is held for one cycle so the sequencer samples it on the next rising edge.
  always @(negedge clk) begin
    mi_output_valid = 1'b0;
    mi_write_ready  = 1'b0;
    mi_data_out     = 32'h0;
    if (reset) begin
      pendActive = 0;
    end else begin
      if (pendActive) begin
        if (pendCnt == 0) begin
          pendActive = 0;
          if (pendLoad) begin
            case (pendType)
              2'b10:   mi_data_out = {mem[pendAddr], mem[pendAddr + 1'b1]};
              2'b01:   mi_data_out = pendSigned ? {{16{mem[pendAddr][15]}}, mem[pendAddr]}
                                                : {16'h0, mem[pendAddr]};
              default: mi_data_out = pendSigned ? {{24{mem[pendAddr][7]}}, mem[pendAddr][7:0]}
                                                : {24'h0, mem[pendAddr][7:0]};
            endcase
            mi_output_valid = 1'b1;
          end else begin
            case (pendType)
              2'b10: begin
                mem[pendAddr]        = pendData[31:16];
                mem[pendAddr + 1'b1] = pendData[15:0];
              end
              2'b01:   mem[pendAddr]      = pendData[15:0];
              default: mem[pendAddr][7:0] = pendData[7:0];
            endcase
            mi_write_ready = 1'b1;
          end
        end else begin
          pendCnt--;
        end
      end
      if (mi_load)  loadPulses++;
      if (mi_store) storePulses++;
      if (mi_load || mi_store) begin
        lastWordType = mi_word_type;
        lastAddr     = mi_address;
        if (!memNoResp) begin
          pendActive = 1;
          pendLoad   = mi_load;
          pendAddr   = mi_address;
          pendData   = mi_data_in;
          pendType   = mi_word_type;
          pendSigned = mi_is_signed;
          pendCnt    = memLatency;
        end
      end
    end
  end

  // Single comparison point: every check in the bench goes through here.
  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one request starting on a falling edge, queues its expected
  // response and returns just after the rising edge that accepts it.
  task automatic applyStimulus(input logic isStore, input logic [ADDR_WIDTH-1:0] addr,
                               input logic [31:0] wdata, input logic [1:0] wordType,
                               input logic sgn, input logic [RD_WIDTH-1:0] rd,
                               input logic expIsLoad, input logic [31:0] expData,
                               input logic expErr);
    rsp_t e;
    @(negedge clk);
    req_is_store  = isStore;
    req_addr      = addr;
    req_wdata     = wdata;
    req_word_type = wordType;
    req_signed    = sgn;
    req_rd        = rd;
    req_valid     = 1'b1;
    e.isLoad = expIsLoad;
    e.rd     = rd;
    e.data   = expData;
    e.err    = expErr;
    expQ.push_back(e);
    check("reqReadyIdle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits (bounded) for the response, compares it against the scoreboard,
  // optionally stalls writeback for holdCycles, then completes the handshake.
  task automatic checkOutput(input string tag, input int holdCycles, input int expCycles);
    int   cycles = 0;
    bit   seen   = 0;
    rsp_t e;
    while (!seen && cycles < TIMEOUT + 20) begin
      @(negedge clk);
      cycles++;
      if (rsp_valid) seen = 1;
    end
    check({tag, ".rspSeen"}, 32'(seen), 32'd1);
    if (!seen) begin
      if (expQ.size() > 0) void'(expQ.pop_front());
      return;
    end
    e = expQ.pop_front();
    if (expCycles > 0) check({tag, ".latency"}, 32'(cycles), 32'(expCycles));
    check({tag, ".isLoad"}, 32'(rsp_is_load), 32'(e.isLoad));
    check({tag, ".rd"},     32'(rsp_rd),      32'(e.rd));
    check({tag, ".data"},   rsp_data,         e.data);
    check({tag, ".err"},    32'(rsp_err),     32'(e.err));
    check({tag, ".reqReadyResp"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      check({tag, ".holdValid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".holdData"},  rsp_data,       e.data);
      check({tag, ".holdRd"},    32'(rsp_rd),    32'(e.rd));
      check({tag, ".holdReady"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".rspDropped"}, 32'(rsp_valid), 32'd0);
    check({tag, ".backIdle"},   32'(req_ready), 32'd1);
  endtask

  initial begin
    int baseLoad;
    int baseStore;

    for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 16'h0;
    mem[12'h010] = 16'h1234;
    mem[12'h011] = 16'hABCD;

    reset         = 1'b1;
    req_valid     = 1'b0;
    req_is_store  = 1'b0;
    req_addr      = '0;
    req_wdata     = 32'h0;
    req_word_type = 2'b00;
    req_signed    = 1'b0;
    req_rd        = '0;
    mi_busy       = 1'b0;
    rsp_ready     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.reqReady",  32'(req_ready),  32'd1);
    check("rst.miLoad",    32'(mi_load),    32'd0);
    check("rst.miStore",   32'(mi_store),   32'd0);
    check("rst.miAddress", 32'(mi_address), 32'd0);
    check("rst.rspValid",  32'(rsp_valid),  32'd0);
    check("rst.rspData",   rsp_data,        32'd0);
    check("rst.rspErr",    32'(rsp_err),    32'd0);
    reset = 1'b0;

    // Word load with zero memory latency: three cycles accept -> response
    memLatency = 0;
    baseLoad = loadPulses;
    applyStimulus(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 4'd5, 1'b1, 32'h1234ABCD, 1'b0);
    checkOutput("wordLoad", 0, 3);
    check("wordLoad.pulses", 32'(loadPulses - baseLoad), 32'd1);

    // Signed byte store, then signed byte read-back
    memLatency = 2;
    baseStore = storePulses;
    applyStimulus(1'b1, 12'h020, 32'h000000F0, 2'b00, 1'b1, 4'd0, 1'b0, 32'h0, 1'b0);
    checkOutput("byteStore", 0, -1);
    check("byteStore.pulses",   32'(storePulses - baseStore), 32'd1);
    check("byteStore.wordType", 32'(lastWordType), 32'd0);
    check("byteStore.addr",     32'(lastAddr),     32'h020);
    applyStimulus(1'b0, 12'h020, 32'h0, 2'b00, 1'b1, 4'd7, 1'b1, 32'hFFFFFFF0, 1'b0);
    checkOutput("byteReadBack", 0, -1);

    // Rejected requests never strobe memory and respond the next cycle
    baseLoad = loadPulses;
    applyStimulus(1'b0, 12'hFFF, 32'h0, 2'b10, 1'b0, 4'd3, 1'b0, 32'h0, 1'b1);
    checkOutput("wordAtLast", 0, 1);
    applyStimulus(1'b0, 12'h100, 32'h0, 2'b11, 1'b0, 4'd4, 1'b0, 32'h0, 1'b1);
    checkOutput("illegalType", 0, 1);
    check("reject.pulses", 32'(loadPulses - baseLoad), 32'd0);

    // Busy memory_interface holds the strobe back
    memLatency = 1;
    mi_busy = 1'b1;
    baseLoad = loadPulses;
    applyStimulus(1'b0, 12'h011, 32'h0, 2'b01, 1'b0, 4'd2, 1'b1, 32'h0000ABCD, 1'b0);
    repeat (5) @(negedge clk);
    check("busy.noPulse", 32'(loadPulses - baseLoad), 32'd0);
    @(posedge clk);
    #1 mi_busy = 1'b0;
    checkOutput("busyLoad", 0, -1);
    check("busy.onePulse", 32'(loadPulses - baseLoad), 32'd1);

    // Silent memory: timeout after TIMEOUT cycles in WAIT
    memNoResp = 1;
    applyStimulus(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 4'd9, 1'b0, 32'h0, 1'b1);
    checkOutput("timeout", 0, TIMEOUT + 2);
    memNoResp = 0;
    memLatency = 0;
    applyStimulus(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 4'd6, 1'b1, 32'h1234ABCD, 1'b0);
    checkOutput("afterTimeout", 0, 3);

    // Writeback stalls for four cycles
    memLatency = 3;
    applyStimulus(1'b0, 12'h010, 32'h0, 2'b01, 1'b1, 4'd11, 1'b1, 32'h00001234, 1'b0);
    checkOutput("rspStall", 4, -1);

    // Reset in WAIT aborts the access with no response
    memNoResp = 1;
    applyStimulus(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 4'd8, 1'b1, 32'h1234ABCD, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midRst.miAddress", 32'(mi_address), 32'd0);
    check("midRst.miWordType", 32'(mi_word_type), 32'd0);
    check("midRst.rspValid",  32'(rsp_valid),  32'd0);
    check("midRst.reqReady",  32'(req_ready),  32'd1);
    void'(expQ.pop_front());
    @(negedge clk);
    reset = 1'b0;
    memNoResp = 0;
    repeat (3) @(negedge clk);
    check("midRst.noRsp", 32'(rsp_valid), 32'd0);
    check("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
